// File: rtl/uart_rx.sv
// uart_rx: bus-attached 8N1 UART receiver with RX FIFO, status/control registers and level IRQ.
//   clk_i           system clock
//   rst_ni          synchronous active-low reset
//   device_req_i    single-cycle bus request, always accepted
//   device_addr_i   byte address, word offset taken from bits [3:2]
//   device_we_i     write enable
//   device_be_i     byte enables, writes act only when bit 0 is set
//   device_wdata_i  write data
//   device_rvalid_o response valid, one cycle after every request
//   device_rdata_o  registered read data, 0 for writes
//   uart_rx_i       asynchronous serial input, idle high
//   rx_irq_o        level interrupt
module uart_rx #(
   parameter int unsigned ClockFrequency = 50_000_000,
   parameter int unsigned BaudRate       = 115_200,
   parameter int unsigned RxFifoDepth    = 8
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        device_req_i,
   input  logic [31:0] device_addr_i,
   input  logic        device_we_i,
   input  logic [3:0]  device_be_i,
   input  logic [31:0] device_wdata_i,
   output logic        device_rvalid_o,
   output logic [31:0] device_rdata_o,
   input  logic        uart_rx_i,
   output logic        rx_irq_o
);
   localparam int unsigned ClocksPerBit = ClockFrequency / BaudRate;
   localparam int unsigned CntW = $clog2(ClocksPerBit + 1);
   localparam int unsigned PtrW = $clog2(RxFifoDepth);
   localparam int unsigned NumW = PtrW + 1;
   // The cycle counter expires at zero, so a reload of N-1 spans N cycles.
   localparam logic [CntW-1:0] BitReload  = CntW'(ClocksPerBit - 1);
   localparam logic [CntW-1:0] HalfReload = CntW'(ClocksPerBit / 2 - 1);

   if (ClocksPerBit < 4) begin : g_cpb_check
      $error("uart_rx: ClocksPerBit must be at least 4");
   end
   if (RxFifoDepth < 2 || (RxFifoDepth & (RxFifoDepth - 1)) != 0) begin : g_depth_check
      $error("uart_rx: RxFifoDepth must be a power of two and at least 2");
   end

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

   state_e          state_q;
   logic [CntW-1:0] cyc_q;
   logic [2:0]      bit_q;
   logic [7:0]      shift_q;
   logic [1:0]      sync_q;
   logic            rx_s;

   logic [7:0]      mem_q [RxFifoDepth];
   logic [PtrW-1:0] rptr_q, wptr_q;
   logic [NumW-1:0] num_q;
   logic            ov_q, fe_q;
   logic [1:0]      ctrl_q;
   logic            rvalid_q, irq_q;
   logic [31:0]     rdata_q;

   logic        frame_done, frame_ok, frame_bad;
   logic        empty, full, rd, wr, pop, push, ovr_set;
   logic [1:0]  sel;
   logic [31:0] rd_data;

   assign rx_s       = sync_q[1];
   assign frame_done = (state_q == STOP) && (cyc_q == '0);
   assign frame_ok   = frame_done & rx_s;
   assign frame_bad  = frame_done & ~rx_s;

   assign sel     = device_addr_i[3:2];
   assign rd      = device_req_i & ~device_we_i;
   assign wr      = device_req_i & device_we_i & device_be_i[0];
   assign empty   = num_q == '0;
   assign full    = num_q == NumW'(RxFifoDepth);
   assign pop     = rd & (sel == 2'd0) & ~empty;
   // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
   assign push    = frame_ok & (~full | pop);
   assign ovr_set = frame_ok & full & ~pop;

   assign rd_data = (sel == 2'd0) ? {24'b0, empty ? 8'h00 : mem_q[rptr_q]} :
                    (sel == 2'd1) ? 32'({num_q, 3'b000, fe_q, ov_q, full, ~empty}) :
                    (sel == 2'd2) ? {30'b0, ctrl_q} : 32'b0;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         cyc_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         sync_q  <= 2'b11;
      end else begin
         sync_q <= {sync_q[0], uart_rx_i};
         unique case (state_q)
            IDLE: if (!rx_s) begin
               bit_q   <= '0;
               cyc_q   <= HalfReload;
               state_q <= START;
            end
            START: if (cyc_q != '0) cyc_q <= cyc_q - 1'b1;
               else if (rx_s) state_q <= IDLE;
               else begin
                  cyc_q   <= BitReload;
                  state_q <= DATA;
               end
            DATA: if (cyc_q != '0) cyc_q <= cyc_q - 1'b1;
               else begin
                  shift_q <= {rx_s, shift_q[7:1]};
                  cyc_q   <= BitReload;
                  bit_q   <= bit_q + 1'b1;
                  if (bit_q == 3'd7) state_q <= STOP;
               end
            STOP: if (cyc_q != '0) cyc_q <= cyc_q - 1'b1;
               else state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) mem_q[wptr_q] <= shift_q;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         rptr_q   <= '0;
         wptr_q   <= '0;
         num_q    <= '0;
         ov_q     <= 1'b0;
         fe_q     <= 1'b0;
         ctrl_q   <= '0;
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
         irq_q    <= 1'b0;
      end else begin
         if (push) wptr_q <= wptr_q + 1'b1;
         if (pop) rptr_q <= rptr_q + 1'b1;
         num_q    <= num_q + NumW'(push) - NumW'(pop);
         // Set events take priority over a simultaneous clear.
         ov_q     <= ovr_set | (ov_q & ~(wr & (sel == 2'd1) & device_wdata_i[2]));
         fe_q     <= frame_bad | (fe_q & ~(wr & (sel == 2'd1) & device_wdata_i[3]));
         if (wr && sel == 2'd2) ctrl_q <= device_wdata_i[1:0];
         rvalid_q <= device_req_i;
         rdata_q  <= rd ? rd_data : 32'b0;
         irq_q    <= (ctrl_q[0] & ~empty) | (ctrl_q[1] & (ov_q | fe_q));
      end
   end

   assign device_rvalid_o = rvalid_q;
   assign device_rdata_o  = rdata_q;
   assign rx_irq_o        = irq_q;
endmodule
